// File: rtl/mux2_ne_1.sv
// 2:1 selector with combinational result, enable-loaded registered copy, and saturating select-toggle counter.
// Latency: dalja 0 cycles; dalja_q/valid_q/toggles 1 cycle.
// Backpressure: none, the block is always ready.
module mux2_ne_1 #(
    parameter int WIDTH = 1,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] hyrja1,
    input  logic [WIDTH-1:0] hyrja2,
    input  logic             sinjali,
    input  logic             en,
    output logic [WIDTH-1:0] dalja,
    output logic [WIDTH-1:0] dalja_q,
    output logic             valid_q,
    output logic [CNT_W-1:0] toggles
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic sel_hist;

    // Ternary keeps an X select visible as X in simulation without a latch.
    assign dalja = sinjali ? hyrja2 : hyrja1;

    always_ff @(posedge clk) begin
        if (reset) begin
            dalja_q  <= '0;
            valid_q  <= 1'b0;
            toggles  <= '0;
            sel_hist <= 1'b0;
        end else begin
            if (en) begin
                dalja_q <= dalja;
                valid_q <= 1'b1;
            end
            sel_hist <= sinjali;
            if ((sinjali != sel_hist) && (toggles != CNT_MAX))
                toggles <= toggles + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_mux2_ne_1.sv
// Drives three mux2_ne_1 configurations (narrow, narrow with 2-bit counter, 8-bit wide)
// with directed and random stimulus, checked against a per-cycle reference model.
module tb_mux2_ne_1;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] h1 [3];
    logic [7:0] h2 [3];
    logic       s  [3];
    logic       en [3];

    logic       d0, q0, v0;
    logic [7:0] t0;
    logic       d1, q1, v1;
    logic [1:0] t1;
    logic [7:0] d2, q2;
    logic       v2;
    logic [7:0] t2;

    int n_vec = 0;
    int n_err = 0;

    int m_q    [3];
    int m_vld  [3];
    int m_cnt  [3];
    int m_prev [3];

    always #5 clk = ~clk;

    mux2_ne_1 #(.WIDTH(1), .CNT_W(8)) u_dut (
        .clk(clk), .reset(reset), .hyrja1(h1[0][0:0]), .hyrja2(h2[0][0:0]),
        .sinjali(s[0]), .en(en[0]), .dalja(d0), .dalja_q(q0), .valid_q(v0), .toggles(t0)
    );

    mux2_ne_1 #(.WIDTH(1), .CNT_W(2)) u_sat (
        .clk(clk), .reset(reset), .hyrja1(h1[1][0:0]), .hyrja2(h2[1][0:0]),
        .sinjali(s[1]), .en(en[1]), .dalja(d1), .dalja_q(q1), .valid_q(v1), .toggles(t1)
    );

    mux2_ne_1 #(.WIDTH(8), .CNT_W(8)) u_wide (
        .clk(clk), .reset(reset), .hyrja1(h1[2]), .hyrja2(h2[2]),
        .sinjali(s[2]), .en(en[2]), .dalja(d2), .dalja_q(q2), .valid_q(v2), .toggles(t2)
    );

    function automatic int wmask(int k);
        return (k == 2) ? 255 : 1;
    endfunction

    function automatic int cmax(int k);
        return (k == 1) ? 3 : 255;
    endfunction

    function automatic int sel_val(int k);
        return (s[k] ? int'(h2[k]) : int'(h1[k])) & wmask(k);
    endfunction

    // Reference: what each counter/register should hold after every rising edge.
    always @(posedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (reset) begin
                m_q[k]    <= 0;
                m_vld[k]  <= 0;
                m_cnt[k]  <= 0;
                m_prev[k] <= 0;
            end else begin
                if (en[k]) begin
                    m_q[k]   <= sel_val(k);
                    m_vld[k] <= 1;
                end
                m_prev[k] <= int'(s[k]);
                if (int'(s[k]) != m_prev[k])
                    m_cnt[k] <= (m_cnt[k] < cmax(k)) ? m_cnt[k] + 1 : m_cnt[k];
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] get_d(int k);
        case (k)
            0:       return {31'd0, d0};
            1:       return {31'd0, d1};
            default: return {24'd0, d2};
        endcase
    endfunction

    function automatic logic [31:0] get_q(int k);
        case (k)
            0:       return {31'd0, q0};
            1:       return {31'd0, q1};
            default: return {24'd0, q2};
        endcase
    endfunction

    function automatic logic [31:0] get_v(int k);
        case (k)
            0:       return {31'd0, v0};
            1:       return {31'd0, v1};
            default: return {31'd0, v2};
        endcase
    endfunction

    function automatic logic [31:0] get_t(int k);
        case (k)
            0:       return {24'd0, t0};
            1:       return {30'd0, t1};
            default: return {24'd0, t2};
        endcase
    endfunction

    task automatic check_all(input string tag);
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("%s_d%0d", tag, k), get_d(k), 32'(sel_val(k)));
            chk($sformatf("%s_q%0d", tag, k), get_q(k), 32'(m_q[k]));
            chk($sformatf("%s_v%0d", tag, k), get_v(k), 32'(m_vld[k]));
            chk($sformatf("%s_t%0d", tag, k), get_t(k), 32'(m_cnt[k]));
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        logic [7:0] tt_exp;
        logic [2:0] v;
        tt_exp = 8'b1101_1000;  // dalja for (h1,h2,s)=111..000, msb first
        reset = 1'b1;
        for (int k = 0; k < 3; k++) begin
            h1[k] = 8'($urandom); h2[k] = 8'($urandom);
            s[k] = 1'($urandom); en[k] = 1'b1;
        end
        @(negedge clk);
        tick();
        tick();
        chk("rst_q0", get_q(0), 32'd0);
        chk("rst_v0", get_v(0), 32'd0);
        chk("rst_t0", get_t(0), 32'd0);
        check_all("rst");

        // Exhaustive truth table in 5 ns steps while reset holds registered state.
        for (int i = 0; i < 8; i++) begin
            v = 3'(i);
            h1[0] = {7'd0, v[2]}; h2[0] = {7'd0, v[1]}; s[0] = v[0];
            #1;
            chk($sformatf("tt%0d", i), get_d(0), {31'd0, tt_exp[i]});
            #4;
        end
        @(negedge clk);

        reset = 1'b0;
        h1[0] = 8'd1; h2[0] = 8'd0; s[0] = 1'b0; en[0] = 1'b1;
        tick();
        chk("ld_q", get_q(0), 32'd1);
        chk("ld_v", get_v(0), 32'd1);
        en[0] = 1'b0; s[0] = 1'b1;
        #1;
        chk("hold_d", get_d(0), 32'd0);
        tick();
        chk("hold_q", get_q(0), 32'd1);
        check_all("ld");

        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int k = 0; k < 3; k++) s[k] = 1'b0;
        for (int c = 0; c < 6; c++) begin
            if (c < 5) s[0] = ~s[0];
            s[1] = ~s[1];
            tick();
        end
        chk("tog5", get_t(0), 32'd5);
        chk("sat3", get_t(1), 32'd3);
        s[1] = ~s[1];
        tick();
        s[1] = ~s[1];
        tick();
        chk("sat_hold", get_t(1), 32'd3);
        check_all("tog");
        reset = 1'b1;
        tick();
        chk("sat_rst", get_t(1), 32'd0);
        reset = 1'b0;

        h1[2] = 8'hA5; h2[2] = 8'h3C; s[2] = 1'b0;
        #1;
        chk("wide_s0", get_d(2), 32'hA5);
        s[2] = 1'b1;
        #1;
        chk("wide_s1", get_d(2), 32'h3C);
        @(negedge clk);

        for (int c = 0; c < 400; c++) begin
            reset = ($urandom_range(0, 31) == 0);
            for (int k = 0; k < 3; k++) begin
                h1[k] = 8'($urandom); h2[k] = 8'($urandom);
                s[k]  = ($urandom_range(0, 3) != 0) ? ~s[k] : s[k];
                en[k] = 1'($urandom);
            end
            #1;
            for (int k = 0; k < 3; k++)
                chk($sformatf("rnd_d%0d", k), get_d(k), 32'(sel_val(k)));
            tick();
            check_all("rnd");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
